acia_sram_loader: RTL and testbench
===================================

Name: acia_sram_loader

Overview:
- Bus master for the ACIA register interface (cs/we/rs/din/dout); sits directly upstream of the ACIA and drives its CPU-side bus in place of the 6502.
- Polls ACIA status, parses a framed serial download, writes the payload into external SRAM, then answers the host with ACK/NAK through the ACIA transmitter.
- Used to load program images into SRAM over the UART before the CPU is released.

Parameters:
- SYNC_BYTE, 8'h55, frame start marker
- ACK_BYTE, 8'h06, reply sent on good checksum
- NAK_BYTE, 8'h15, reply sent on bad checksum or timeout
- TIMEOUT_CYCLES, 24'd4000000, maximum idle clk cycles between bytes inside a frame; 24-bit counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- acia_cs  out  1  ACIA chip select, active high
- acia_we  out  1  ACIA write enable, 1 = write, 0 = read
- acia_rs  out  1  register select, 0 = control/status, 1 = data
- acia_din  out  8  data written to ACIA
- acia_dout  in  8  ACIA read data, valid the cycle after a read strobe; status bit0 = RDRF, bit1 = TDRE
- sram_we  out  1  SRAM write strobe, one-cycle pulse
- sram_addr  out  16  SRAM address
- sram_dout  out  8  SRAM write data
- busy  out  1  high from sync accepted until reply byte written
- done  out  1  one-cycle pulse when ACK written
- err  out  1  one-cycle pulse when NAK written

Behaviour:
- Reset (async assert, sync release): all outputs 0; state = POLL_RX; phase = SYNC; counters 0.
- Bus cycle: strobe outputs (acia_cs, acia_we, acia_rs, acia_din) are registered and held for exactly one clk. For reads, acia_dout is sampled on the following clk. acia_cs must never be high on two consecutive cycles.
- States:
  - POLL_RX: cs=1, we=0, rs=0 -> RX_STAT.
  - RX_STAT: if acia_dout[0], go to RD_DATA; else go to POLL_RX.
  - RD_DATA: cs=1, we=0, rs=1 -> RX_BYTE.
  - RX_BYTE: capture acia_dout, dispatch on phase, clear timeout counter.
  - POLL_TX: cs=1, we=0, rs=0 -> TX_STAT.
  - TX_STAT: if acia_dout[1], go to WR_DATA; else go to POLL_TX.
  - WR_DATA: cs=1, we=1, rs=1, din = reply; pulse done or err; drop busy -> POLL_RX with phase SYNC.
- Frame phases in RX_BYTE:
  - SYNC: byte == SYNC_BYTE -> ADDR_HI and set busy; any other byte is discarded and phase stays SYNC.
  - ADDR_HI -> ADDR_LO: address[15:8] <= byte; next phase ADDR_LO.
  - ADDR_LO: address[7:0] <= byte; next phase LEN.
  - LEN: remaining <= (byte == 0) ? 256 : byte (9-bit); checksum <= 0; next phase DATA.
  - DATA:
    - Same cycle: sram_we=1, sram_addr=address, sram_dout=byte.
    - address <= address+1, wrapping FFFF->0000 without error.
    - checksum <= checksum + byte (mod 256); remaining <= remaining-1.
    - When remaining reaches 0, next phase is CSUM.
  - CSUM: reply = (byte == checksum) ? ACK_BYTE : NAK_BYTE; go to POLL_TX.
- sram_addr/sram_dout hold their last values when sram_we is low.
- Timeout:
  - Counter runs only while phase != SYNC and state is POLL_RX/RX_STAT.
  - On reaching TIMEOUT_CYCLES: reply = NAK_BYTE, go to POLL_TX. SRAM bytes already written are not rolled back.
- A second SYNC_BYTE inside DATA is treated as data.
- Reset mid-frame: abort immediately; no reply is sent; SRAM write in flight may or may not complete.

Decomposition:
- Shared package: ACIA register-select constants (RS_STAT=0, RS_DATA=1), status bit indices (RDRF=0, TDRE=1), state enum, and frame-phase enum.
- One natural sub-module: acia_bus_master, which sequences a single read or write strobe plus sample and returns a done/valid handshake. The loader FSM sits on top of it.

Test Plan:
- Frame 55 12 34 03 AA BB CC 31 (checksum 0x31) -> SRAM writes 1234=AA, 1235=BB, 1236=CC; ACIA data write 06; done pulse; busy low afterwards.
- Same frame with checksum byte 00 -> same three SRAM writes; reply 15; err pulse; no done.
- Leading garbage 00 FF then a valid frame -> garbage ignored with no busy and no SRAM writes; frame processed normally.
- Frame 55 FF FF 02 01 02 03 -> writes FFFF=01 and 0000=02 (address wrap); reply 06.
- LEN=00 -> exactly 256 SRAM writes before checksum phase.
- Frame stops after LEN byte; hold RDRF=0 for TIMEOUT_CYCLES (bench sets it to 100) -> reply 15 with err pulse; a following valid frame is accepted.
- TDRE held 0 for 50 cycles before reply -> loader keeps polling, never writes data early, and writes exactly once when TDRE rises.
- Assert reset during DATA -> all outputs 0 immediately; the next frame starts cleanly from SYNC.

Source files
------------

// File: rtl/acia_sram_loader_pkg.sv
// Shared definitions for the ACIA-driven SRAM loader: register selects,
// status bit positions and the state encodings used by the loader and
// its bus master.
package acia_sram_loader_pkg;

    // ACIA register select values
    localparam logic RS_STAT = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // ACIA status register bit positions
    localparam int RDRF = 0;
    localparam int TDRE = 1;

    // Loader FSM states; TX_WAIT lets the reply write strobe finish before
    // the next poll is issued.
    typedef enum logic [2:0] {
        POLL_RX,
        RX_STAT,
        RD_DATA,
        RX_BYTE,
        POLL_TX,
        TX_STAT,
        WR_DATA,
        TX_WAIT
    } state_t;

    // Position inside the download frame
    typedef enum logic [2:0] {
        PH_SYNC,
        PH_ADDR_HI,
        PH_ADDR_LO,
        PH_LEN,
        PH_DATA,
        PH_CSUM
    } phase_t;

    // Bus master sequencing
    typedef enum logic [1:0] {
        BM_IDLE,
        BM_STROBE,
        BM_SAMPLE
    } bm_state_t;

endpackage

// File: rtl/acia_sram_loader_bus_master.sv
// Runs one ACIA bus cycle per request: a single-cycle registered strobe,
// then for reads a wait cycle and a sample of acia_dout. done pulses once
// the cycle is complete; rdata is valid alongside it for reads.
module acia_bus_master
    import acia_sram_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       wr,
    input  logic       sel,
    input  logic [7:0] wdata,
    input  logic [7:0] acia_dout,
    output logic       acia_cs,
    output logic       acia_we,
    output logic       acia_rs,
    output logic [7:0] acia_din,
    output logic       done,
    output logic [7:0] rdata
);

    bm_state_t bst;
    logic      is_wr;

    // Strobe, wait for ACIA read data, sample, and report completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bst      <= BM_IDLE;
            is_wr    <= 1'b0;
            acia_cs  <= 1'b0;
            acia_we  <= 1'b0;
            acia_rs  <= 1'b0;
            acia_din <= 8'h00;
            done     <= 1'b0;
            rdata    <= 8'h00;
        end else begin
            done <= 1'b0;
            case (bst)
                BM_IDLE: begin
                    if (req) begin
                        acia_cs  <= 1'b1;
                        acia_we  <= wr;
                        acia_rs  <= sel;
                        acia_din <= wr ? wdata : 8'h00;
                        is_wr    <= wr;
                        bst      <= BM_STROBE;
                    end
                end
                BM_STROBE: begin
                    // Strobe lasts exactly one cycle; the ACIA registers
                    // its read data on this edge.
                    acia_cs  <= 1'b0;
                    acia_we  <= 1'b0;
                    acia_rs  <= 1'b0;
                    acia_din <= 8'h00;
                    if (is_wr) begin
                        done <= 1'b1;
                        bst  <= BM_IDLE;
                    end else begin
                        bst <= BM_SAMPLE;
                    end
                end
                BM_SAMPLE: begin
                    rdata <= acia_dout;
                    done  <= 1'b1;
                    bst   <= BM_IDLE;
                end
                default: bst <= BM_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/acia_sram_loader.sv
// Serial download loader: polls the ACIA receiver, parses
// SYNC / ADDR_HI / ADDR_LO / LEN / DATA... / CSUM frames, writes the
// payload to SRAM and answers with ACK or NAK through the transmitter.
module acia_sram_loader
    import acia_sram_loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        acia_cs,
    output logic        acia_we,
    output logic        acia_rs,
    output logic [7:0]  acia_din,
    input  logic [7:0]  acia_dout,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state;
    phase_t      phase;
    logic [15:0] addr;
    logic [8:0]  remaining;
    logic [7:0]  csum;
    logic [7:0]  reply;
    logic        reply_ok;
    logic [23:0] tmo_cnt;

    logic        bm_req;
    logic        bm_wr;
    logic        bm_sel;
    logic [7:0]  bm_wdata;
    logic        bm_done;
    logic [7:0]  bm_rdata;

    acia_bus_master u_bus (
        .clk       (clk),
        .reset     (reset),
        .req       (bm_req),
        .wr        (bm_wr),
        .sel       (bm_sel),
        .wdata     (bm_wdata),
        .acia_dout (acia_dout),
        .acia_cs   (acia_cs),
        .acia_we   (acia_we),
        .acia_rs   (acia_rs),
        .acia_din  (acia_din),
        .done      (bm_done),
        .rdata     (bm_rdata)
    );

    // Loader FSM: receive polling, frame parsing, SRAM writes and reply
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= POLL_RX;
            phase     <= PH_SYNC;
            addr      <= 16'h0000;
            remaining <= 9'd0;
            csum      <= 8'h00;
            reply     <= 8'h00;
            reply_ok  <= 1'b0;
            tmo_cnt   <= 24'd0;
            bm_req    <= 1'b0;
            bm_wr     <= 1'b0;
            bm_sel    <= 1'b0;
            bm_wdata  <= 8'h00;
            sram_we   <= 1'b0;
            sram_addr <= 16'h0000;
            sram_dout <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            bm_req  <= 1'b0;
            sram_we <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;

            // Inter-byte idle time only counts while waiting for receive data
            // inside a frame; it saturates rather than wrapping.
            if (phase != PH_SYNC && (state == POLL_RX || state == RX_STAT) &&
                tmo_cnt != 24'hFFFFFF)
                tmo_cnt <= tmo_cnt + 24'd1;

            case (state)
                POLL_RX: begin
                    if (phase != PH_SYNC && tmo_cnt >= TIMEOUT_CYCLES) begin
                        reply    <= NAK_BYTE;
                        reply_ok <= 1'b0;
                        state    <= POLL_TX;
                    end else begin
                        bm_req <= 1'b1;
                        bm_wr  <= 1'b0;
                        bm_sel <= RS_STAT;
                        state  <= RX_STAT;
                    end
                end
                RX_STAT: begin
                    if (bm_done)
                        state <= bm_rdata[RDRF] ? RD_DATA : POLL_RX;
                end
                RD_DATA: begin
                    bm_req <= 1'b1;
                    bm_wr  <= 1'b0;
                    bm_sel <= RS_DATA;
                    state  <= RX_BYTE;
                end
                RX_BYTE: begin
                    if (bm_done) begin
                        tmo_cnt <= 24'd0;
                        state   <= POLL_RX;
                        case (phase)
                            PH_SYNC: begin
                                if (bm_rdata == SYNC_BYTE) begin
                                    phase <= PH_ADDR_HI;
                                    busy  <= 1'b1;
                                end
                            end
                            PH_ADDR_HI: begin
                                addr[15:8] <= bm_rdata;
                                phase      <= PH_ADDR_LO;
                            end
                            PH_ADDR_LO: begin
                                addr[7:0] <= bm_rdata;
                                phase     <= PH_LEN;
                            end
                            PH_LEN: begin
                                remaining <= (bm_rdata == 8'h00) ? 9'd256 : {1'b0, bm_rdata};
                                csum      <= 8'h00;
                                phase     <= PH_DATA;
                            end
                            PH_DATA: begin
                                sram_we   <= 1'b1;
                                sram_addr <= addr;
                                sram_dout <= bm_rdata;
                                addr      <= addr + 16'd1;
                                csum      <= csum + bm_rdata;
                                remaining <= remaining - 9'd1;
                                if (remaining == 9'd1)
                                    phase <= PH_CSUM;
                            end
                            PH_CSUM: begin
                                reply_ok <= (bm_rdata == csum);
                                reply    <= (bm_rdata == csum) ? ACK_BYTE : NAK_BYTE;
                                state    <= POLL_TX;
                            end
                            default: phase <= PH_SYNC;
                        endcase
                    end
                end
                POLL_TX: begin
                    bm_req <= 1'b1;
                    bm_wr  <= 1'b0;
                    bm_sel <= RS_STAT;
                    state  <= TX_STAT;
                end
                TX_STAT: begin
                    if (bm_done)
                        state <= bm_rdata[TDRE] ? WR_DATA : POLL_TX;
                end
                WR_DATA: begin
                    bm_req   <= 1'b1;
                    bm_wr    <= 1'b1;
                    bm_sel   <= RS_DATA;
                    bm_wdata <= reply;
                    done     <= reply_ok;
                    err      <= ~reply_ok;
                    busy     <= 1'b0;
                    phase    <= PH_SYNC;
                    tmo_cnt  <= 24'd0;
                    state    <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (bm_done)
                        state <= POLL_RX;
                end
                default: state <= POLL_RX;
            endcase
        end
    end

endmodule

// File: tb/tb_acia_sram_loader.sv
// Bench for acia_sram_loader: behavioural ACIA and SRAM models around the
// DUT, directed frames from the test plan plus randomized frames, each
// checked against a frame-level reference model.
module tb_acia_sram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        acia_cs, acia_we, acia_rs;
    logic [7:0]  acia_din;
    logic [7:0]  acia_dout = 8'h00;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_dout;
    logic        busy, done, err;

    always #5 clk = ~clk;

    acia_sram_loader #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk       (clk),
        .reset     (reset),
        .acia_cs   (acia_cs),
        .acia_we   (acia_we),
        .acia_rs   (acia_rs),
        .acia_din  (acia_din),
        .acia_dout (acia_dout),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Host-to-ACIA byte FIFO: the initial block owns the write index,
    // the ACIA model owns the read index.
    logic [7:0]  rx_buf [0:8191];
    int          rx_wr = 0;
    int          rx_rd = 0;
    logic        tdre = 1'b1;

    logic [7:0]  tx_log [$];
    logic [23:0] wr_log [$];
    int          done_n = 0, err_n = 0, busy_n = 0;
    int          early_wr = 0, cs_double = 0;
    logic        prev_cs = 1'b0;

    // ACIA and SRAM behaviour plus output monitors
    always @(posedge clk) begin
        prev_cs <= acia_cs;
        if (acia_cs && prev_cs) cs_double <= cs_double + 1;
        if (acia_cs && !acia_we) begin
            if (acia_rs) begin
                if (rx_rd != rx_wr) begin
                    acia_dout <= rx_buf[rx_rd % 8192];
                    rx_rd     <= rx_rd + 1;
                end else begin
                    acia_dout <= 8'h00;
                end
            end else begin
                acia_dout <= {6'b0, tdre, (rx_rd != rx_wr)};
            end
        end
        if (acia_cs && acia_we && acia_rs) begin
            tx_log.push_back(acia_din);
            if (!tdre) early_wr <= early_wr + 1;
        end
        if (sram_we) wr_log.push_back({sram_addr, sram_dout});
        if (done) done_n <= done_n + 1;
        if (err)  err_n  <= err_n + 1;
        if (busy) busy_n <= busy_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_buf[rx_wr % 8192] = b;
        rx_wr = rx_wr + 1;
    endtask

    // Reference model inputs/outputs
    logic [7:0]  stream [$];
    logic [23:0] exp_w [$];
    logic [7:0]  exp_reply;
    logic        exp_ok;

    // Frame-level reference: skip to the first sync byte, then write LEN
    // payload bytes at consecutive (wrapping) addresses and ACK only if the
    // checksum byte is present and equals the byte sum mod 256.
    task automatic model();
        int i;
        int len;
        int ci;
        logic [15:0] a;
        logic [7:0]  sum;
        i = 0;
        sum = 8'h00;
        exp_w.delete();
        exp_ok = 1'b0;
        while (i < stream.size() && stream[i] != 8'h55) i++;
        if (i + 3 < stream.size()) begin
            a   = {stream[i+1], stream[i+2]};
            len = (stream[i+3] == 8'h00) ? 256 : int'(stream[i+3]);
            for (int k = 0; k < len; k++) begin
                if (i + 4 + k < stream.size()) begin
                    exp_w.push_back({a + 16'(k), stream[i+4+k]});
                    sum = sum + stream[i+4+k];
                end
            end
            ci = i + 4 + len;
            exp_ok = (ci < stream.size()) && (stream[ci] == sum);
        end
        exp_reply = exp_ok ? 8'h06 : 8'h15;
    endtask

    // Send the current stream and compare everything the frame produces
    task automatic run_stream(input string tag, input bit hold_tdre);
        int w0, t0, d0, e0, n, bad;
        w0 = wr_log.size();
        t0 = tx_log.size();
        d0 = done_n;
        e0 = err_n;
        model();
        if (hold_tdre) tdre = 1'b0;
        foreach (stream[k]) push(stream[k]);
        if (hold_tdre) begin
            n = 0;
            while (rx_rd != rx_wr && n < 20000) begin @(negedge clk); n++; end
            repeat (50) @(negedge clk);
            check({tag, ".quiet_while_tdre_low"}, tx_log.size() - t0, 0);
            tdre = 1'b1;
        end
        n = 0;
        while (tx_log.size() == t0 && n < 30000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check({tag, ".reply_count"}, tx_log.size() - t0, 1);
        check({tag, ".reply"}, (tx_log.size() > t0) ? tx_log[t0] : 8'hXX, exp_reply);
        check({tag, ".write_count"}, wr_log.size() - w0, exp_w.size());
        bad = 0;
        foreach (exp_w[k])
            if (w0 + k >= wr_log.size() || wr_log[w0+k] !== exp_w[k]) bad++;
        check({tag, ".write_data"}, bad, 0);
        check({tag, ".done_cycles"}, done_n - d0, exp_ok ? 1 : 0);
        check({tag, ".err_cycles"}, err_n - e0, exp_ok ? 0 : 1);
        check({tag, ".busy_after"}, busy, 0);
    endtask

    task automatic rand_frame(input int len, input bit good, input int garbage);
        logic [7:0]  s;
        logic [7:0]  g;
        logic [15:0] a;
        s = 8'h00;
        a = 16'($urandom);
        stream.delete();
        for (int k = 0; k < garbage; k++) begin
            g = 8'($urandom);
            if (g == 8'h55) g = 8'h54;
            stream.push_back(g);
        end
        stream.push_back(8'h55);
        stream.push_back(a[15:8]);
        stream.push_back(a[7:0]);
        stream.push_back(8'(len));
        for (int k = 0; k < ((len == 0) ? 256 : len); k++) begin
            g = 8'($urandom);
            stream.push_back(g);
            s = s + g;
        end
        stream.push_back(good ? s : s + 8'(1 + $urandom_range(0, 254)));
    endtask

    initial begin
        int w0, b0, n;

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.acia", {acia_cs, acia_we, acia_rs, acia_din}, 0);
        check("rst.sram", {sram_we, sram_addr, sram_dout}, 0);
        check("rst.status", {busy, done, err}, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Good and bad checksum on the reference frame
        stream = '{8'h55, 8'h12, 8'h34, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
        run_stream("ack_frame", 1'b0);
        stream = '{8'h55, 8'h12, 8'h34, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00};
        run_stream("nak_frame", 1'b0);

        // Leading garbage is ignored
        w0 = wr_log.size();
        b0 = busy_n;
        push(8'h00);
        push(8'hFF);
        n = 0;
        while (rx_rd != rx_wr && n < 2000) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        check("garbage.busy_cycles", busy_n - b0, 0);
        check("garbage.writes", wr_log.size() - w0, 0);
        stream = '{8'h55, 8'h40, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
        run_stream("after_garbage", 1'b0);

        // Address wrap
        stream = '{8'h55, 8'hFF, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h03};
        run_stream("addr_wrap", 1'b0);

        // LEN = 0 means 256 bytes
        rand_frame(0, 1'b1, 0);
        run_stream("len_256", 1'b0);

        // Frame stalls after LEN: timeout NAK, then a normal frame
        stream = '{8'h55, 8'h00, 8'h10, 8'h05};
        run_stream("timeout", 1'b0);
        rand_frame(4, 1'b1, 0);
        run_stream("after_timeout", 1'b0);

        // Transmitter busy for a while before the reply
        rand_frame(3, 1'b1, 0);
        run_stream("tdre_hold", 1'b1);

        // Reset in the middle of DATA
        w0 = wr_log.size();
        rand_frame(16, 1'b1, 0);
        foreach (stream[k]) push(stream[k]);
        n = 0;
        while (wr_log.size() < w0 + 3 && n < 5000) begin @(negedge clk); n++; end
        #2 reset = 1'b0;
        #1;
        check("midreset.outputs",
              {acia_cs, acia_we, acia_rs, acia_din, sram_we, sram_addr, sram_dout, busy, done, err}, 0);
        repeat (2) @(negedge clk);
        rx_wr = rx_rd;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rand_frame(5, 1'b1, 0);
        run_stream("after_midreset", 1'b0);

        // Randomized frames
        for (int r = 0; r < 12; r++) begin
            rand_frame($urandom_range(1, 12), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
            run_stream($sformatf("rand%0d", r), 1'b0);
        end

        check("no_write_while_tdre_low", early_wr, 0);
        check("cs_never_back_to_back", cs_double, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
